dwt_decim_fifo: RTL and testbench



---
 rtl/dwt_decim_fifo.sv | 141 ++++++++++++++
 tb/tb_dwt_decim_fifo.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/dwt_decim_fifo.sv
// Decimate-by-2 stage behind the first-level polyphase DWT filter: keeps one phase per pair,
// scales by 1/256 toward zero and streams (lo, hi) pairs from a FWFT FIFO. Odd phase: DWT_DECIM_ODD_EN.
module dwt_decim_fifo #(
  parameter int unsigned y_out = 25,
  parameter int unsigned DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic signed [y_out-1:0] hi_y0,
  input  logic signed [y_out-1:0] hi_y1,
  input  logic signed [y_out-1:0] hi_y2,
  input  logic signed [y_out-1:0] hi_y3,
  input  logic signed [y_out-1:0] hi_y4,
  input  logic signed [y_out-1:0] hi_y5,
  input  logic signed [y_out-1:0] lo_y0,
  input  logic signed [y_out-1:0] lo_y1,
  input  logic signed [y_out-1:0] lo_y2,
  input  logic signed [y_out-1:0] lo_y3,
  input  logic signed [y_out-1:0] lo_y4,
  input  logic signed [y_out-1:0] lo_y5,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic signed [y_out-1:0] out_lo,
  output logic signed [y_out-1:0] out_hi,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [$clog2(DEPTH):0]  level
);

  localparam int unsigned PtrW  = $clog2(DEPTH);
  localparam int unsigned LvlW  = PtrW + 1;
  localparam int unsigned PairW = 2 * y_out;

  typedef logic [PtrW-1:0] ptr_t;
  typedef logic [LvlW-1:0] lvl_t;

  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : gen_depth_check
    $error("dwt_decim_fifo: DEPTH must be a power of two and at least 4");
  end

  // Divide by 256 truncating toward zero: bias negatives by 255 before the arithmetic shift.
  function automatic logic signed [y_out-1:0] scale(input logic signed [y_out-1:0] s);
    logic signed [y_out:0] ext;
    logic signed [y_out:0] shifted;
    ext = {s[y_out-1], s};
    if (s[y_out-1]) begin
      ext = ext + {{(y_out - 7){1'b0}}, 8'hff};
    end
    shifted = ext >>> 8;
    return shifted[y_out-1:0];
  endfunction

  logic signed [y_out-1:0] sel_lo [3];
  logic signed [y_out-1:0] sel_hi [3];
  logic [PairW-1:0]        wdata  [3];
  logic [PairW-1:0]        mem_q  [DEPTH];
  logic [PairW-1:0]        head;

  ptr_t wr_ptr_q, wr_ptr_d;
  ptr_t rd_ptr_q, rd_ptr_d;
  lvl_t level_q, level_d;
  logic push, pop;

  always_comb begin
`ifdef DWT_DECIM_ODD_EN
    sel_lo[0] = lo_y1;
    sel_lo[1] = lo_y3;
    sel_lo[2] = lo_y5;
    sel_hi[0] = hi_y1;
    sel_hi[1] = hi_y3;
    sel_hi[2] = hi_y5;
`else
    sel_lo[0] = lo_y0;
    sel_lo[1] = lo_y2;
    sel_lo[2] = lo_y4;
    sel_hi[0] = hi_y0;
    sel_hi[1] = hi_y2;
    sel_hi[2] = hi_y4;
`endif
  end

  always_comb begin
    for (int k = 0; k < 3; k++) begin
      wdata[k] = {scale(sel_lo[k]), scale(sel_hi[k])};
    end
  end

  // Flags depend on registered occupancy only, so in_ready never sees out_ready.
  always_comb begin
    in_ready  = (level_q <= lvl_t'(DEPTH - 3));
    out_valid = (level_q != '0);
    push      = in_valid & in_ready;
    pop       = out_valid & out_ready;
    level     = level_q;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + ptr_t'(3);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + ptr_t'(1);
    end
    level_d = level_q + (push ? lvl_t'(3) : lvl_t'(0)) - (pop ? lvl_t'(1) : lvl_t'(0));
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage is deliberately not reset; it is only visible while level is non-zero.
  always_ff @(posedge clk) begin
    if (push) begin
      for (int k = 0; k < 3; k++) begin
        mem_q[wr_ptr_q + ptr_t'(k)] <= wdata[k];
      end
    end
  end

  always_comb begin
    head   = mem_q[rd_ptr_q];
    out_lo = '0;
    out_hi = '0;
    if (out_valid) begin
      out_lo = head[PairW-1 -: y_out];
      out_hi = head[y_out-1:0];
    end
  end

endmodule

// File: tb/tb_dwt_decim_fifo.sv
// Self-checking bench for dwt_decim_fifo: queue-based reference model plus directed scenarios.
module tb_dwt_decim_fifo;

  localparam int unsigned YW    = 25;
  localparam int unsigned DEPTH = 8;
`ifdef DWT_DECIM_ODD_EN
  localparam int PH = 1;
`else
  localparam int PH = 0;
`endif

  logic                 clk;
  logic                 rstn;
  logic signed [YW-1:0] lo [6];
  logic signed [YW-1:0] hi [6];
  logic                 in_valid;
  logic                 in_ready;
  logic signed [YW-1:0] out_lo;
  logic signed [YW-1:0] out_hi;
  logic                 out_valid;
  logic                 out_ready;
  logic [3:0]           level;

  int checks = 0;
  int errors = 0;
  int pops   = 0;
  int accepted = 0;

  logic signed [YW-1:0] q_lo [$];
  logic signed [YW-1:0] q_hi [$];

  dwt_decim_fifo #(.y_out(YW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rstn(rstn),
    .hi_y0(hi[0]), .hi_y1(hi[1]), .hi_y2(hi[2]), .hi_y3(hi[3]), .hi_y4(hi[4]), .hi_y5(hi[5]),
    .lo_y0(lo[0]), .lo_y1(lo[1]), .lo_y2(lo[2]), .lo_y3(lo[3]), .lo_y4(lo[4]), .lo_y5(lo[5]),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_lo(out_lo), .out_hi(out_hi), .out_valid(out_valid), .out_ready(out_ready),
    .level(level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic signed [YW-1:0] ref_scale(input logic signed [YW-1:0] s);
    int v;
    v = s;
    return YW'(v / 256);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d, expected %0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  task automatic rand_group();
    for (int i = 0; i < 6; i++) begin
      lo[i] = YW'($urandom);
      hi[i] = YW'($urandom);
    end
  endtask

  // Check all outputs against the model, apply one clock, then update the model.
  task automatic cycle();
    int n;
    bit push, pop;
    logic signed [YW-1:0] e_lo, e_hi;
    n    = q_lo.size();
    e_lo = (n != 0) ? q_lo[0] : '0;
    e_hi = (n != 0) ? q_hi[0] : '0;
    chk("in_ready", 64'(in_ready), 64'(int'(DEPTH) - n >= 3));
    chk("out_valid", 64'(out_valid), 64'(n != 0));
    chk("level", 64'(level), 64'(n));
    chk("out_lo", out_lo, e_lo);
    chk("out_hi", out_hi, e_hi);
    push = in_valid && (int'(DEPTH) - n >= 3);
    pop  = out_ready && (n != 0);
    @(posedge clk);
    #1;
    if (pop) begin
      void'(q_lo.pop_front());
      void'(q_hi.pop_front());
      pops++;
    end
    if (push) begin
      for (int k = 0; k < 3; k++) begin
        q_lo.push_back(ref_scale(lo[2 * k + PH]));
        q_hi.push_back(ref_scale(hi[2 * k + PH]));
      end
      accepted++;
      rand_group();
    end
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 40 && q_lo.size() != 0; c++) cycle();
    chk("drained_level", 64'(level), 64'd0);
  endtask

  int d_lo [3];
  int d_hi [3];
  logic signed [YW-1:0] saved;
  int pops0, acc0;

  initial begin
`ifdef DWT_DECIM_ODD_EN
    d_lo = '{0, 0, 0};
    d_hi = '{0, 0, 0};
`else
    d_lo = '{1, 2, -2};
    d_hi = '{-1, 3, 0};
`endif
    rstn = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    rand_group();
    #3;
    chk("rst_level", 64'(level), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_lo", out_lo, 64'd0);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;

    // Single group
    lo = '{256, 1, 512, 2, -512, 3};
    hi = '{-256, 0, 768, 0, 255, 0};
    in_valid = 1'b1; out_ready = 1'b1;
    cycle();
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("single_level", 64'(level), 64'(3 - k));
      chk("single_lo", out_lo, 64'(d_lo[k]));
      chk("single_hi", out_hi, 64'(d_hi[k]));
      cycle();
    end
    chk("single_empty", 64'(level), 64'd0);

    // Backpressure
    rand_group();
    in_valid = 1'b1; out_ready = 1'b0;
    repeat (4) cycle();
    chk("bp_level", 64'(level), 64'd6);
    chk("bp_in_ready", 64'(in_ready), 64'd0);
    chk("bp_accepted", 64'(accepted), 64'd3);
    in_valid = 1'b0; out_ready = 1'b1;
    cycle();
    chk("bp_level5", 64'(level), 64'd5);
    chk("bp_ready_back", 64'(in_ready), 64'd1);
    drain();

    // Simultaneous accept and pop
    in_valid = 1'b1; out_ready = 1'b0;
    cycle();
    in_valid = 1'b0; out_ready = 1'b1;
    cycle();
    chk("sim_level2", 64'(level), 64'd2);
    saved = q_lo[1];
    in_valid = 1'b1;
    cycle();
    chk("sim_level4", 64'(level), 64'd4);
    chk("sim_new_head", out_lo, saved);
    drain();

    // Rounding boundaries
    lo = '{-1, -1, -255, -255, -256, -256};
    hi = '{-257, -257, 255, 255, 65535, 65535};
    in_valid = 1'b1; out_ready = 1'b0;
    cycle();
    in_valid = 1'b0;
    chk("rnd_lo0", out_lo, 64'd0);
    chk("rnd_hi0", out_hi, -64'sd1);
    out_ready = 1'b1;
    cycle();
    chk("rnd_lo1", out_lo, 64'd0);
    chk("rnd_hi1", out_hi, 64'd0);
    cycle();
    chk("rnd_lo2", out_lo, -64'sd1);
    chk("rnd_hi2", out_hi, 64'd255);
    drain();

    // Random stalls across pointer wrap
    pops0 = pops;
    acc0  = accepted;
    for (int c = 0; c < 3000 && (accepted - acc0 < 20 || q_lo.size() != 0); c++) begin
      in_valid  = (accepted - acc0 < 20) && ($urandom_range(0, 2) != 0);
      out_ready = ($urandom_range(0, 9) < 7);
      cycle();
    end
    chk("wrap_groups", 64'(accepted - acc0), 64'd20);
    chk("wrap_pairs", 64'(pops - pops0), 64'd60);
    drain();

    // Reset mid-stream
    in_valid = 1'b1; out_ready = 1'b0;
    repeat (2) cycle();
    in_valid = 1'b0; out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    chk("mid_level5", 64'(level), 64'd5);
    #2 rstn = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_lo", out_lo, 64'd0);
    chk("mid_rst_hi", out_hi, 64'd0);
    chk("mid_rst_level", 64'(level), 64'd0);
    chk("mid_rst_ready", 64'(in_ready), 64'd1);
    q_lo.delete();
    q_hi.delete();
    @(posedge clk);
    #1 rstn = 1'b1;
    rand_group();
    in_valid = 1'b1; out_ready = 1'b1;
    cycle();
    in_valid = 1'b0;
    chk("post_rst_level", 64'(level), 64'd3);
    repeat (4) cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
